// File: rtl/sbus_pkg.sv
// Shared SBUS types for the requester side.
//   tSbusAdr   : word address, bits [12:35]; [34:35] is the word offset
//   tSbusRq    : request mask, RQ[i] selects offset (adr[34:35]+i) mod 4
//   tWord      : 36-bit data word
//   tWo        : 2-bit word offset
//   tInitState : initiator FSM states
package sbus_pkg;

  typedef logic [12:35] tSbusAdr;
  typedef logic [0:3]   tSbusRq;
  typedef logic [0:35]  tWord;
  typedef logic [34:35] tWo;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2
  } tInitState;

endpackage

// File: rtl/sbus_rq_walker.sv
// Combinational request-mask walker.
// Ports:
//   rq      in  request mask
//   ordinal in  which set bit to locate (0 = first set bit)
//   offset  out mask index of that set bit, relative to the start offset
//   found   out the mask has at least ordinal+1 set bits
//   count   out number of set bits in rq
module sbus_rq_walker
  import sbus_pkg::*;
(
  input  tSbusRq     rq,
  input  logic [1:0] ordinal,
  output logic [1:0] offset,
  output logic       found,
  output logic [2:0] count
);

  always_comb begin
    offset = '0;
    found  = 1'b0;
    count  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (rq[i]) begin
        // count is at most 3 before this increment, so the low bits suffice
        if (count[1:0] == ordinal) begin
          offset = 2'(i);
          found  = 1'b1;
        end
        count = count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/sbus_initiator.sv
// SBUS read requester for one memory phase.
// Accepts a quadword read request, issues one START with ADR/RQ, counts
// ACKN rising edges, captures one word per VALID rising edge and returns it
// with its word offset. A silent memory is reported as NXM after TIMEOUT
// idle cycles.
// Ports:
//   CLK, RESET_N            clock, asynchronous active-low reset
//   reqValid/reqReady       request handshake; reqAdr, reqRq request fields
//   START, ADR, RQ          SBUS request outputs (ADR/RQ valid with START)
//   ACKN, VALID, D          SBUS acknowledge, data-valid and data inputs
//   rspValid, rspWo, rspData returned word and its offset (one cycle)
//   rspDone, rspNxm         transaction end, ended by timeout
//   protoErr                unexpected ACKN/VALID rising edge
module sbus_initiator
  import sbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic    CLK,
  input  logic    RESET_N,
  input  logic    reqValid,
  output logic    reqReady,
  input  tSbusAdr reqAdr,
  input  tSbusRq  reqRq,
  output logic    START,
  output tSbusAdr ADR,
  output tSbusRq  RQ,
  input  logic    ACKN,
  input  logic    VALID,
  input  tWord    D,
  output logic    rspValid,
  output tWo      rspWo,
  output tWord    rspData,
  output logic    rspDone,
  output logic    rspNxm,
  output logic    protoErr
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  tInitState      state, state_nxt;
  tSbusAdr        adr_q;
  tSbusRq         rq_q;
  logic [2:0]     ack_cnt, dat_cnt, n_words;
  logic [2:0]     ack_next, dat_next;
  logic [TW-1:0]  tmo;
  logic           ackn_q, valid_q;
  logic           ack_edge, valid_edge, activity;
  logic           ack_take, dat_take;
  logic           accept, null_req, complete, timeout, proto;
  logic [1:0]     walk_off;
  logic           walk_found;

  sbus_rq_walker u_walker (
    .rq      (rq_q),
    .ordinal (dat_cnt[1:0]),
    .offset  (walk_off),
    .found   (walk_found),
    .count   (n_words)
  );

  assign ack_edge   = ACKN & ~ackn_q;
  assign valid_edge = VALID & ~valid_q;
  assign activity   = ack_edge | valid_edge;

  // Edges are only counted while collecting and while below the word count;
  // any other edge is a protocol error.
  assign ack_take = (state == COLLECT) && ack_edge && (ack_cnt < n_words);
  assign dat_take = (state == COLLECT) && valid_edge && (dat_cnt < n_words) && walk_found;
  assign proto    = (ack_edge && !ack_take) || (valid_edge && !dat_take);

  assign ack_next = ack_cnt + {2'b00, ack_take};
  assign dat_next = dat_cnt + {2'b00, dat_take};

  assign reqReady = (state == IDLE);
  assign START    = (state == ISSUE);
  assign ADR      = START ? adr_q : '0;
  assign RQ       = START ? rq_q  : '0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    null_req  = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (reqValid) begin
          if (reqRq != '0) begin
            accept    = 1'b1;
            state_nxt = ISSUE;
          end else begin
            null_req = 1'b1;
          end
        end
      end
      ISSUE: state_nxt = COLLECT;
      COLLECT: begin
        if (ack_next == n_words && dat_next == n_words) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (!activity && tmo == TW'(TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The START cycle counts as the first idle cycle, so the timeout counter
  // restarts at 1 and NXM is reported TIMEOUT cycles after START.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      adr_q    <= '0;
      rq_q     <= '0;
      ack_cnt  <= '0;
      dat_cnt  <= '0;
      tmo      <= '0;
      ackn_q   <= 1'b0;
      valid_q  <= 1'b0;
      rspValid <= 1'b0;
      rspWo    <= '0;
      rspData  <= '0;
      rspDone  <= 1'b0;
      rspNxm   <= 1'b0;
      protoErr <= 1'b0;
    end else begin
      ackn_q   <= ACKN;
      valid_q  <= VALID;
      rspValid <= dat_take;
      rspDone  <= complete | timeout | null_req;
      rspNxm   <= timeout;
      protoErr <= proto;
      if (accept) begin
        adr_q <= reqAdr;
        rq_q  <= reqRq;
      end
      if (state == ISSUE) begin
        ack_cnt <= '0;
        dat_cnt <= '0;
        tmo     <= TW'(1);
      end else if (state == COLLECT) begin
        ack_cnt <= ack_next;
        dat_cnt <= dat_next;
        tmo     <= activity ? TW'(1) : tmo + TW'(1);
        if (dat_take) begin
          rspData <= D;
          rspWo   <= adr_q[34:35] + walk_off;
        end
      end
    end
  end

endmodule

// File: tb/tb_sbus_initiator.sv
// Self-checking bench for sbus_initiator: table of read transactions with
// hand-computed word offsets, plus directed sequences for null request,
// NXM timeout, protocol error, level-held strobes and mid-transaction reset.
module tb_sbus_initiator;
  import sbus_pkg::*;

  logic    CLK = 1'b0;
  logic    RESET_N = 1'b0;
  logic    reqValid = 1'b0;
  logic    reqReady;
  tSbusAdr reqAdr = '0;
  tSbusRq  reqRq = '0;
  logic    START;
  tSbusAdr ADR;
  tSbusRq  RQ;
  logic    ACKN = 1'b0;
  logic    VALID = 1'b0;
  tWord    D = '0;
  logic    rspValid;
  tWo      rspWo;
  tWord    rspData;
  logic    rspDone;
  logic    rspNxm;
  logic    protoErr;

  int nvec = 0;
  int nerr = 0;

  sbus_initiator #(.TIMEOUT(64)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .reqValid(reqValid), .reqReady(reqReady), .reqAdr(reqAdr), .reqRq(reqRq),
    .START(START), .ADR(ADR), .RQ(RQ),
    .ACKN(ACKN), .VALID(VALID), .D(D),
    .rspValid(rspValid), .rspWo(rspWo), .rspData(rspData),
    .rspDone(rspDone), .rspNxm(rspNxm), .protoErr(protoErr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    tSbusAdr    adr;
    tSbusRq     rq;
    int         n;
    logic [7:0] wo;   // {wo3, wo2, wo1, wo0}
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic tWord mkdata(input int id, input int w);
    return 36'o123400000000 + 36'(id * 8 + w);
  endfunction

  task automatic check_reset_values(input string nm);
    chk({nm, "_reqReady"}, reqReady, 1);
    chk({nm, "_START"}, START, 0);
    chk({nm, "_ADR"}, ADR, 0);
    chk({nm, "_RQ"}, RQ, 0);
    chk({nm, "_rspValid"}, rspValid, 0);
    chk({nm, "_rspWo"}, rspWo, 0);
    chk({nm, "_rspData"}, rspData, 0);
    chk({nm, "_rspDone"}, rspDone, 0);
    chk({nm, "_rspNxm"}, rspNxm, 0);
    chk({nm, "_protoErr"}, protoErr, 0);
  endtask

  task automatic issue(input tSbusAdr adr, input tSbusRq rq);
    int guard = 0;
    while (!reqReady && guard < 20) begin
      step();
      guard++;
    end
    chk("req_ready", reqReady, 1);
    reqValid = 1'b1; reqAdr = adr; reqRq = rq;
    step();
    reqValid = 1'b0; reqAdr = '0; reqRq = '0;
    chk("start", START, 1);
    chk("start_adr", ADR, adr);
    chk("start_rq", RQ, rq);
    chk("busy", reqReady, 0);
    step();
    chk("start_pulse", START, 0);
  endtask

  // One word: ACKN and VALID rise together, then drop for one cycle.
  task automatic word(input int id, input int w, input tWo wo, input logic last);
    ACKN = 1'b1; VALID = 1'b1; D = mkdata(id, w);
    step();
    ACKN = 1'b0; VALID = 1'b0; D = '0;
    chk("rsp_valid", rspValid, 1);
    chk("rsp_wo", rspWo, wo);
    chk("rsp_data", rspData, mkdata(id, w));
    chk("rsp_done", rspDone, last);
    chk("ready_at_done", reqReady, last);
    chk("rsp_nxm", rspNxm, 0);
    chk("proto_quiet", protoErr, 0);
    step();
    chk("rsp_gap", rspValid, 0);
    chk("done_pulse", rspDone, 0);
  endtask

  task automatic run_txn(input tSbusAdr adr, input tSbusRq rq, input int n,
                         input logic [7:0] wo, input int id);
    issue(adr, rq);
    for (int w = 0; w < n; w++) word(id, w, wo[2*w +: 2], w == n - 1);
    chk("idle_after", reqReady, 1);
  endtask

  initial begin
    logic flag;

    vecs[0] = '{adr: 24'o001002, rq: 4'b1111, n: 4, wo: {2'd1, 2'd0, 2'd3, 2'd2}};
    vecs[1] = '{adr: 24'o000001, rq: 4'b0101, n: 2, wo: {2'd0, 2'd0, 2'd0, 2'd2}};
    vecs[2] = '{adr: 24'o000001, rq: 4'b1010, n: 2, wo: {2'd0, 2'd0, 2'd3, 2'd1}};
    vecs[3] = '{adr: 24'o777777, rq: 4'b0010, n: 1, wo: {2'd0, 2'd0, 2'd0, 2'd1}};
    vecs[4] = '{adr: 24'o123450, rq: 4'b0111, n: 3, wo: {2'd0, 2'd3, 2'd2, 2'd1}};
    vecs[5] = '{adr: 24'o000002, rq: 4'b1001, n: 2, wo: {2'd0, 2'd0, 2'd1, 2'd2}};

    #2;
    check_reset_values("reset");
    step();
    RESET_N = 1'b1;
    step();

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].adr, vecs[i].rq, vecs[i].n, vecs[i].wo, i);

    // Null request: no START, rspDone next cycle, still ready.
    reqValid = 1'b1; reqRq = '0; reqAdr = 24'o000017;
    step();
    reqValid = 1'b0; reqAdr = '0;
    chk("null_done", rspDone, 1);
    chk("null_nostart", START, 0);
    chk("null_ready", reqReady, 1);
    chk("null_nxm", rspNxm, 0);
    step();
    chk("null_done_pulse", rspDone, 0);
    chk("null_nostart2", START, 0);

    // NXM: memory silent, rspDone/rspNxm exactly 64 cycles after START.
    reqValid = 1'b1; reqAdr = 24'o000000; reqRq = 4'b1000;
    step();
    reqValid = 1'b0; reqRq = '0;
    chk("nxm_start", START, 1);
    flag = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (i < 64 && (rspDone || rspValid)) flag = 1'b1;
    end
    chk("nxm_early", flag, 0);
    chk("nxm_done", rspDone, 1);
    chk("nxm_flag", rspNxm, 1);
    chk("nxm_novalid", rspValid, 0);
    step();
    chk("nxm_done_pulse", rspDone, 0);
    chk("nxm_ready", reqReady, 1);

    // Extra VALID after a completed 1-word read.
    run_txn(24'o000000, 4'b1000, 1, 8'h00, 10);
    VALID = 1'b1; D = 36'o777777777777;
    step();
    VALID = 1'b0; D = '0;
    chk("extra_proto", protoErr, 1);
    chk("extra_novalid", rspValid, 0);
    step();
    chk("extra_proto_pulse", protoErr, 0);

    // Levels: ACKN and VALID held high count once each.
    issue(24'o000000, 4'b1100);
    flag = 1'b0;
    ACKN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (protoErr) flag = 1'b1;
    end
    ACKN = 1'b0;
    VALID = 1'b1; D = mkdata(20, 0);
    step();
    chk("lvl_valid0", rspValid, 1);
    chk("lvl_wo0", rspWo, 0);
    chk("lvl_done0", rspDone, 0);
    D = mkdata(20, 7);
    step();
    chk("lvl_held", rspValid, 0);
    step();
    if (protoErr) flag = 1'b1;
    VALID = 1'b0; ACKN = 1'b1;
    step();
    ACKN = 1'b0;
    step();
    if (protoErr) flag = 1'b1;
    chk("lvl_nodone_yet", rspDone, 0);
    VALID = 1'b1; D = mkdata(20, 1);
    step();
    VALID = 1'b0; D = '0;
    chk("lvl_valid1", rspValid, 1);
    chk("lvl_wo1", rspWo, 1);
    chk("lvl_data1", rspData, mkdata(20, 1));
    chk("lvl_done1", rspDone, 1);
    if (protoErr) flag = 1'b1;
    chk("lvl_noproto", flag, 0);
    step();

    // Reset after 2 of 4 words, then a clean request.
    issue(24'o000003, 4'b1111);
    word(30, 0, 2'd3, 1'b0);
    ACKN = 1'b1; VALID = 1'b1; D = mkdata(30, 1);
    step();
    ACKN = 1'b0; VALID = 1'b0; D = '0;
    chk("rst_pre_valid", rspValid, 1);
    chk("rst_pre_wo", rspWo, 0);
    #2;
    RESET_N = 1'b0;
    #1;
    check_reset_values("midrst");
    step();
    RESET_N = 1'b1;
    step();
    run_txn(24'o000001, 4'b1000, 1, 8'h01, 31);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
